// File: rtl/insn_dispatcher.sv
// insn_dispatcher: buffers 16-bit instructions in a small FIFO and issues the
// decoded head to the datapath controller through a start/waiting handshake.
module insn_dispatcher #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             in_instr,
   input  logic                    flush,
   input  logic                    waiting,
   output logic                    start,
   output logic [2:0]              opcode,
   output logic [1:0]              ALU_op,
   output logic [1:0]              shift_op,
   output logic [2:0]              rn,
   output logic [2:0]              rd,
   output logic [2:0]              rm,
   output logic [7:0]              imm8,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    illegal
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, ACK, EXEC} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   instr_q, instr_d;
   logic          illegal_q, illegal_d;
   logic          push, pop, head_legal;
   logic [15:0]   head;

   assign head       = mem_q[rd_ptr_q];
   assign head_legal = (head[15:13] == 3'b110) || (head[15:13] == 3'b101);
   assign in_ready   = (count_q < FULL) & ~rst;
   // flush wins over a same-cycle push and cancels a pending pop
   assign push       = in_valid & in_ready & ~flush;
   assign pop        = (state_q == IDLE) && (count_q != '0) && waiting && !flush;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (head_legal) begin
                  instr_d = head;
                  state_d = ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ISSUE:   state_d = ACK;
         // waiting still high here means the controller never saw start
         ACK:     state_d = waiting ? ISSUE : EXEC;
         EXEC:    if (waiting) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         instr_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         instr_q   <= instr_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_instr;
   end

   assign start    = (state_q == ISSUE);
   assign busy     = (state_q != IDLE);
   assign count    = count_q;
   assign illegal  = illegal_q;
   assign opcode   = instr_q[15:13];
   assign ALU_op   = instr_q[12:11];
   assign rn       = instr_q[10:8];
   assign rd       = instr_q[7:5];
   assign shift_op = instr_q[4:3];
   assign rm       = instr_q[2:0];
   assign imm8     = instr_q[7:0];

endmodule

// File: tb/tb_insn_dispatcher.sv
// Bench for insn_dispatcher: a queue of accepted instructions is the reference;
// a negedge monitor plays the controller and scores every issue and drop.
module tb_insn_dispatcher;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_instr = 16'h0000;
   logic        flush = 1'b0;
   logic        waiting = 1'b1;
   logic        in_ready, start, busy, illegal;
   logic [2:0]  opcode, rn, rd, rm;
   logic [1:0]  ALU_op, shift_op;
   logic [7:0]  imm8;
   logic [2:0]  count;
   logic [23:0] dut_fields;

   insn_dispatcher #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .flush(flush), .waiting(waiting), .start(start),
      .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op), .rn(rn), .rd(rd),
      .rm(rm), .imm8(imm8), .busy(busy), .count(count), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign dut_fields = {opcode, ALU_op, rn, rd, shift_op, rm, imm8};

   int checks = 0;
   int failures = 0;

   // reference state
   logic [15:0] exp_q[$];
   logic [15:0] last_instr = 16'h0000;
   logic [15:0] pend_instr = 16'h0000;
   bit pend_push = 0, pend_flush = 0;
   bit inflight = 0, release_pend = 0, repulse_exp = 0;
   int exec_cnt = 0, cyc = 0, last_start_cyc = -100;
   int n_starts = 0, n_repulse = 0, n_illegal = 0;
   // controller-model knobs
   bit ctrl_hold = 0, force_miss = 0;
   int miss_pct = 0, exec_len_fix = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h required=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] fields_of(input logic [15:0] i);
      return {i[15:13], i[12:11], i[10:8], i[7:5], i[4:3], i[2:0], i[7:0]};
   endfunction

   function automatic bit is_legal(input logic [15:0] i);
      return (i[15:13] == 3'b110) || (i[15:13] == 3'b101);
   endfunction

   function automatic logic [15:0] rand_instr(input bit legal_only);
      logic [15:0] w;
      int r;
      w = 16'($urandom);
      r = legal_only ? $urandom_range(0, 5) : $urandom_range(0, 7);
      if (r < 3)      w[15:13] = 3'b110;
      else if (r < 6) w[15:13] = 3'b101;
      return w;
   endfunction

   // monitor + controller model
   always @(negedge clk) begin : monitor
      logic [15:0] e;
      bit fresh;
      if (rst) begin
         chk("rst_start", start, 0);
         chk("rst_busy", busy, 0);
         chk("rst_illegal", illegal, 0);
         chk("rst_count", count, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_fields", dut_fields, 0);
         exp_q.delete();
         last_instr = '0; pend_instr = '0;
         pend_push = 0; pend_flush = 0;
         inflight = 0; release_pend = 0; repulse_exp = 0;
         exec_cnt = 0; cyc = 0; last_start_cyc = -100;
         waiting = !ctrl_hold;
      end else begin
         cyc++;
         if (release_pend) begin
            inflight = 0;
            release_pend = 0;
         end
         fresh = start && !repulse_exp;
         if (start) begin
            n_starts++;
            if (fresh) begin
               chk("start_gap_ge4", (cyc - last_start_cyc) >= 4, 1);
               chk("start_after_flush", pend_flush, 0);
               chk("start_has_entry", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("start_head_legal", is_legal(e), 1);
                  last_instr = e;
               end
               inflight = 1;
               $display("issue   t=%0t instr=%h", $time, last_instr);
            end else begin
               chk("repulse_gap", cyc - last_start_cyc, 2);
               n_repulse++;
               $display("reissue t=%0t instr=%h", $time, last_instr);
            end
            if (force_miss || ($urandom_range(0, 99) < miss_pct)) begin
               force_miss = 0;
               repulse_exp = 1;
            end else begin
               repulse_exp = 0;
               waiting = 0;
               exec_cnt = (exec_len_fix > 0) ? exec_len_fix : $urandom_range(2, 4);
            end
            last_start_cyc = cyc;
         end else if (!waiting) begin
            if (exec_cnt > 0) exec_cnt--;
            if (exec_cnt == 0 && !ctrl_hold) begin
               waiting = 1;
               if (inflight) release_pend = 1;
            end
         end else if (ctrl_hold && !inflight) begin
            waiting = 0;
         end
         if (illegal) begin
            n_illegal++;
            chk("illegal_after_flush", pend_flush, 0);
            chk("illegal_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("illegal_head_is_illegal", is_legal(e), 0);
               $display("drop    t=%0t instr=%h", $time, e);
            end
         end
         if (pend_flush) exp_q.delete();
         else if (pend_push) exp_q.push_back(pend_instr);
         chk("count", count, exp_q.size());
         chk("in_ready", in_ready, exp_q.size() < DEPTH);
         chk("busy", busy, inflight);
         chk("fields", dut_fields, fields_of(last_instr));
         pend_flush = flush;
         pend_push  = in_valid && !flush && (exp_q.size() < DEPTH);
         pend_instr = in_instr;
      end
   end

   task automatic offer(input logic [15:0] w);
      in_valid = 1'b1;
      in_instr = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !inflight && !release_pend && waiting && !pend_push) break;
         @(posedge clk); #1;
      end
      checks++;
      if (i == 300) begin
         failures++;
         $display("FAIL %s_idle: still busy after 300 cycles, required drained", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int s0, r0, i0, k;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single MOV R0,#7 with exact latency
      s0 = n_starts;
      in_valid = 1'b1; in_instr = 16'hD007;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("t1_no_start_yet", start, 0);
      chk("t1_count", count, 1);
      @(negedge clk);
      chk("t1_start", start, 1);
      chk("t1_opcode", opcode, 3'b110);
      chk("t1_alu", ALU_op, 2'b10);
      chk("t1_rn", rn, 3'd0);
      chk("t1_imm8", imm8, 8'h07);
      @(posedge clk); #1;
      wait_idle("t1");
      chk("t1_one_start", n_starts - s0, 1);

      // three back-to-back
      s0 = n_starts;
      offer(16'hD007); offer(16'hA041); offer(16'hA941);
      wait_idle("t2");
      chk("t2_three_starts", n_starts - s0, 3);

      // illegal then legal
      s0 = n_starts; i0 = n_illegal;
      offer(16'h0000); offer(16'hD107);
      wait_idle("t3");
      chk("t3_illegal_once", n_illegal - i0, 1);
      chk("t3_one_start", n_starts - s0, 1);
      chk("t3_rn", rn, 3'd1);
      chk("t3_imm8", imm8, 8'h07);

      // fill while controller busy-holds, 5th refused
      ctrl_hold = 1;
      for (k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (!waiting) break;
      end
      chk("t4_hold_reached", waiting, 0);
      for (int j = 0; j < DEPTH; j++) offer(rand_instr(1));
      in_valid = 1'b1; in_instr = 16'hD0FF;
      @(negedge clk);
      chk("t4_full_in_ready", in_ready, 0);
      chk("t4_full_count", count, DEPTH);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("t4_fifth_dropped", count, DEPTH);
      s0 = n_starts;
      @(posedge clk); #1 ctrl_hold = 0;
      wait_idle("t4");
      chk("t4_four_issues", n_starts - s0, 4);

      // missed start
      s0 = n_starts; r0 = n_repulse;
      force_miss = 1;
      offer(16'hD2AB);
      wait_idle("t5");
      chk("t5_one_repulse", n_repulse - r0, 1);
      chk("t5_two_pulses", n_starts - s0, 2);

      // flush with 3 queued behind an executing instruction
      s0 = n_starts;
      exec_len_fix = 8;
      for (int j = 0; j < 4; j++) offer(rand_instr(1));
      @(negedge clk);
      chk("t6_count_before", count, 3);
      chk("t6_busy_before", busy, 1);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("t6_count_flushed", count, 0);
      @(posedge clk); #1 exec_len_fix = 0;
      wait_idle("t6");
      chk("t6_only_inflight", n_starts - s0, 1);

      // randomized traffic
      miss_pct = 15;
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_instr = rand_instr(0);
         flush    = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; miss_pct = 0;
      wait_idle("random");

      // reset mid-EXEC
      s0 = n_starts;
      exec_len_fix = 6;
      offer(16'hA041);
      repeat (3) @(posedge clk);
      #1 chk("t8_busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t8_start", start, 0);
      chk("t8_busy", busy, 0);
      chk("t8_illegal", illegal, 0);
      chk("t8_count", count, 0);
      chk("t8_in_ready", in_ready, 0);
      chk("t8_fields", dut_fields, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; exec_len_fix = 0;
      repeat (6) @(posedge clk);
      #1 chk("t8_no_start_after", n_starts - s0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
